// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types for the pixel-stream overlay stages.
package vga_pkg;
    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int H_TOTAL   = 800;
    localparam int V_TOTAL   = 525;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    typedef enum logic {IDLE = 1'b0, FLY = 1'b1} meteor_state_t;
endpackage

// File: rtl/meteor_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 7,5,4,3), shifting left, advancing only when adv is high.
module meteor_lfsr8 #(
    parameter logic [7:0] SEED = 8'h5A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    output logic [7:0] value
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   value <= SEED;
        else if (adv) value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
    end
endmodule

// File: rtl/meteor_overlay.sv
// Overlays an occasional diagonal shooting star on the scene stream; all outputs lag inputs by one clock.
module meteor_overlay
    import vga_pkg::*;
#(
    parameter int         TRAIL_LEN = 16,
    parameter int         SPEED     = 4,
    parameter int         MIN_DELAY = 30,
    parameter logic [7:0] LFSR_SEED = 8'h5A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       trigger,
    input  logic       in_r,
    input  logic       in_g,
    input  logic       in_b,
    input  logic       in_hsync_n,
    input  logic       in_vsync_n,
    input  logic       in_active,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    output logic       out_r,
    output logic       out_g,
    output logic       out_b,
    output logic       out_hsync_n,
    output logic       out_vsync_n,
    output logic       busy
);
    localparam logic [10:0] X_EXIT = 11'(H_VISIBLE + TRAIL_LEN);
    localparam logic [10:0] Y_EXIT = 11'(V_VISIBLE + TRAIL_LEN);
    localparam logic [10:0] SPD    = 11'(SPEED);
    localparam logic [10:0] TL     = 11'(TRAIL_LEN);
    localparam logic [10:0] TL_H   = 11'(TRAIL_LEN / 2);
    localparam logic [6:0]  MIN_D  = 7'(MIN_DELAY);

    meteor_state_t state, state_nx;
    logic [10:0]   head_x, head_x_nx, head_y, head_y_nx;
    logic [6:0]    delay_cnt, delay_nx;
    logic          trig_pend, vs_d, frame_tick, spawn;
    logic [7:0]    lfsr;

    assign frame_tick = vs_d & ~in_vsync_n;
    assign spawn      = frame_tick && (state == IDLE) && (trig_pend || delay_cnt == 7'd0);
    assign busy       = (state != IDLE);

    meteor_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (frame_tick),
        .value (lfsr)
    );

    always_comb begin
        state_nx  = state;
        head_x_nx = head_x;
        head_y_nx = head_y;
        delay_nx  = delay_cnt;
        if (frame_tick) begin
            case (state)
                IDLE: begin
                    if (trig_pend || delay_cnt == 7'd0) begin
                        state_nx  = FLY;
                        head_x_nx = {2'b00, lfsr, 1'b0};
                        head_y_nx = 11'd0;
                    end else begin
                        delay_nx = delay_cnt - 7'd1;
                    end
                end
                FLY: begin
                    head_x_nx = head_x + SPD;
                    head_y_nx = head_y + SPD;
                    // Exit once the whole trail has left the visible area.
                    if (head_x_nx >= X_EXIT || head_y_nx >= Y_EXIT) begin
                        state_nx = IDLE;
                        delay_nx = MIN_D + {1'b0, lfsr[5:0]};
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            head_x    <= '0;
            head_y    <= '0;
            delay_cnt <= MIN_D;
            trig_pend <= 1'b0;
            vs_d      <= 1'b1;
        end else begin
            state     <= state_nx;
            head_x    <= head_x_nx;
            head_y    <= head_y_nx;
            delay_cnt <= delay_nx;
            vs_d      <= in_vsync_n;
            if (spawn)                            trig_pend <= 1'b0;
            else if (trigger && state == IDLE)    trig_pend <= 1'b1;
        end
    end

    logic [10:0] dx, dy;
    logic        on;
    rgb_t        met, pix;

    assign dx = head_x - {1'b0, hpos};
    assign dy = head_y - {1'b0, vpos};
    assign on = (state == FLY) && in_active && ({1'b0, hpos} <= head_x) &&
                ({1'b0, vpos} <= head_y) && (dx == dy) && (dx < TL);

    always_comb begin
        if (dx < 11'd2)     met = '{r: 1'b1, g: 1'b1, b: 1'b1};
        else if (dx < TL_H) met = '{r: 1'b1, g: 1'b1, b: 1'b0};
        else                met = '{r: 1'b1, g: 1'b0, b: 1'b0};
        pix = (ena && on) ? met : '{r: in_r, g: in_g, b: in_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {out_r, out_g, out_b}      <= 3'b000;
            {out_hsync_n, out_vsync_n} <= 2'b11;
        end else begin
            {out_r, out_g, out_b}      <= {pix.r, pix.g, pix.b};
            {out_hsync_n, out_vsync_n} <= {in_hsync_n, in_vsync_n};
        end
    end
endmodule
